jpeg_dequantizer: RTL

JPEG_DEQUANTIZER -- requirements
Module: jpeg_dequantizer

---
 rtl/jpeg_dec_pkg.sv | 13 +
 rtl/jpeg_sat_mul.sv | 36 +++
 rtl/jpeg_dequantizer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/jpeg_dec_pkg.sv
// Constants shared by the JPEG dequantizer blocks: block geometry and default datapath widths.
package jpeg_dec_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int IDX_W      = 6;

  localparam int COEF_W_DEF = 12;
  localparam int Q_W_DEF    = 8;
  localparam int OUT_W_DEF  = 16;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

endpackage

// File: rtl/jpeg_sat_mul.sv
// Combinational signed-coefficient x unsigned-table-entry multiply,
// saturated to the signed output range.
module jpeg_sat_mul
  import jpeg_dec_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int Q_W    = Q_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic        [Q_W-1:0]    i_q,
  output logic signed [OUT_W-1:0]  o_prod
);

  // One guard bit over COEF_W+Q_W keeps the zero-extended table entry positive.
  localparam int P_W = COEF_W + Q_W + 1;

  localparam logic signed [P_W-1:0] MAX_V = {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] MIN_V = {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [P_W-1:0] w_a;
  logic signed [P_W-1:0] w_b;
  logic signed [P_W-1:0] w_prod;

  assign w_a    = P_W'(i_coef);
  assign w_b    = P_W'({1'b0, i_q});
  assign w_prod = w_a * w_b;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves o_prod unassigned (avoids a latch).
    o_prod = w_prod[OUT_W-1:0];
    if (w_prod > MAX_V)      o_prod = MAX_V[OUT_W-1:0];
    else if (w_prod < MIN_V) o_prod = MIN_V[OUT_W-1:0];
  end

endmodule

// File: rtl/jpeg_dequantizer.sv
// Two-stage JPEG dequantizer: coefficient x 64-entry quant table, saturated,
// with block framing checks and a globally stalled valid/ready pipeline.
module jpeg_dequantizer
  import jpeg_dec_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int Q_W    = Q_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     qt_wr_en,
  input  logic [IDX_W-1:0]         qt_wr_addr,
  input  logic [Q_W-1:0]           qt_wr_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_coef,
  output logic                     out_last,
  output logic                     busy,
  output logic                     seq_err,
  output logic                     qt_err
);

  logic [Q_W-1:0]           r_qt [BLOCK_SIZE];
  logic [IDX_W-1:0]         r_idx;
  logic                     r_seq_err;
  logic                     r_qt_err;

  logic                     r_s1_valid;
  logic signed [COEF_W-1:0] r_s1_coef;
  logic [Q_W-1:0]           r_s1_q;
  logic                     r_s1_last;

  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_coef;
  logic                     r_out_last;

  logic                     w_en;
  logic                     w_in_fire;
  logic                     w_busy;
  logic                     w_at_last;
  logic signed [OUT_W-1:0]  w_mul;

  // Every stage advances together, so a stalled output freezes the whole pipe.
  assign w_en      = !r_out_valid || out_ready;
  assign w_in_fire = in_valid && w_en;
  assign w_busy    = (r_idx != '0) || r_s1_valid || r_out_valid;
  assign w_at_last = (r_idx == LAST_IDX);

  // NOTE: the table is a register array, not RAM, precisely so reset can load the identity entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_SIZE; i++) r_qt[i] <= Q_W'(1);
    end else if (qt_wr_en && !w_busy) begin
      r_qt[qt_wr_addr] <= qt_wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_seq_err <= 1'b0;
      r_qt_err  <= 1'b0;
    end else begin
      if (qt_wr_en && w_busy) r_qt_err <= 1'b1;
      if (w_in_fire) begin
        r_idx <= (in_last || w_at_last) ? '0 : r_idx + IDX_W'(1);
        if (in_last != w_at_last) r_seq_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_coef   <= '0;
      r_s1_q      <= '0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_coef  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_en) begin
      r_s1_valid  <= w_in_fire;
      if (w_in_fire) begin
        r_s1_coef <= in_coef;
        r_s1_q    <= r_qt[r_idx];
        r_s1_last <= in_last || w_at_last;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_coef <= w_mul;
        r_out_last <= r_s1_last;
      end
    end
  end

  jpeg_sat_mul #(
    .COEF_W (COEF_W),
    .Q_W    (Q_W),
    .OUT_W  (OUT_W)
  ) u_sat_mul (
    .i_coef (r_s1_coef),
    .i_q    (r_s1_q),
    .o_prod (w_mul)
  );

  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out_coef  = r_out_coef;
  assign out_last  = r_out_last;
  assign busy      = w_busy;
  assign seq_err   = r_seq_err;
  assign qt_err    = r_qt_err;

endmodule
